// File: rtl/noc_leaf_pkg.sv
// ============================================================================
// Module   : noc_leaf_pkg
// Brief    : Packet field offsets, widths and match helper for BFT leaf input ports.
// Revision : 1.0
// ============================================================================
`default_nettype none

package noc_leaf_pkg;

   localparam int PACKET_BITS_DEF           = 97;
   localparam int PAYLOAD_BITS_DEF          = 64;
   localparam int NUM_LEAF_BITS_DEF         = 6;
   localparam int NUM_PORT_BITS_DEF         = 4;
   localparam int NUM_IN_PORTS_DEF          = 7;
   localparam int PORT_BASE_DEF             = 2;
   localparam int DATA_USER_IN_DEF          = 32;
   localparam int FIFO_DEPTH_BITS_DEF       = 7;
   localparam int FREESPACE_UPDATE_SIZE_DEF = 64;
   localparam int CNT_BITS_DEF              = 32;

   // Layout, MSB first: vld, dst_leaf, dst_port, src_leaf, src_port, pad, payload
   function automatic int dst_port_lsb(input int p, input int l, input int pb);
      return p - 1 - l - pb;
   endfunction

   function automatic int src_lsb(input int p, input int l, input int pb);
      return p - 1 - 2 * l - 2 * pb;
   endfunction

   function automatic int credit_width(input int size);
      return (size > 1) ? $clog2(size) : 1;
   endfunction

   function automatic logic chan_match(
      input logic        vld,
      input logic        en,
      input logic [31:0] dst_port,
      input logic [31:0] chan_port,
      input logic [31:0] src,
      input logic [31:0] ctrl
   );
      return vld & en & (dst_port == chan_port) & (src == ctrl);
   endfunction

endpackage

`default_nettype wire

// File: rtl/input_port_chan.sv
// ============================================================================
// Module   : input_port_chan
// Brief    : One leaf input channel: packet filter, FWFT FIFO, credit pulse, statistics.
// Revision : 1.0
// ============================================================================
`default_nettype none

module input_port_chan
   import noc_leaf_pkg::*;
#(
   parameter int PACKET_BITS           = PACKET_BITS_DEF,
   parameter int NUM_LEAF_BITS         = NUM_LEAF_BITS_DEF,
   parameter int NUM_PORT_BITS         = NUM_PORT_BITS_DEF,
   parameter int CHAN_PORT             = PORT_BASE_DEF,
   parameter int DATA_USER_IN          = DATA_USER_IN_DEF,
   parameter int FIFO_DEPTH_BITS       = FIFO_DEPTH_BITS_DEF,
   parameter int FREESPACE_UPDATE_SIZE = FREESPACE_UPDATE_SIZE_DEF,
   parameter int CNT_BITS              = CNT_BITS_DEF
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [PACKET_BITS-1:0]                 i_stream_in,
   input  logic [NUM_LEAF_BITS+NUM_PORT_BITS-1:0] i_ctrl,
   input  logic                                   i_enable,
   input  logic                                   i_ack,
   input  logic                                   i_done_mode,
   output logic                                   o_freespace_update,
   output logic [DATA_USER_IN-1:0]                o_dout,
   output logic                                   o_vld,
   output logic                                   o_overflow,
   output logic                                   o_stall,
   output logic [CNT_BITS-1:0]                    o_full_cnt,
   output logic [CNT_BITS-1:0]                    o_empty_cnt,
   output logic [CNT_BITS-1:0]                    o_read_cnt
);

   localparam int c_DEPTH    = 2 ** FIFO_DEPTH_BITS;
   localparam int c_SRC_BITS = NUM_LEAF_BITS + NUM_PORT_BITS;
   localparam int c_DST_LSB  = dst_port_lsb(PACKET_BITS, NUM_LEAF_BITS, NUM_PORT_BITS);
   localparam int c_SRC_LSB  = src_lsb(PACKET_BITS, NUM_LEAF_BITS, NUM_PORT_BITS);
   localparam int c_CW       = credit_width(FREESPACE_UPDATE_SIZE);

   localparam logic [FIFO_DEPTH_BITS:0] c_FULL_COUNT  = (FIFO_DEPTH_BITS+1)'(c_DEPTH);
   localparam logic [c_CW-1:0]          c_CREDIT_LAST = c_CW'(FREESPACE_UPDATE_SIZE - 1);

   logic [DATA_USER_IN-1:0]    r_mem [c_DEPTH];
   logic [FIFO_DEPTH_BITS-1:0] r_wr_ptr;
   logic [FIFO_DEPTH_BITS-1:0] r_rd_ptr;
   logic [FIFO_DEPTH_BITS:0]   r_count;
   logic [c_CW-1:0]            r_credit;
   logic                       r_freespace_update;
   logic                       r_overflow;
   logic [CNT_BITS-1:0]        r_full_cnt;
   logic [CNT_BITS-1:0]        r_empty_cnt;
   logic [CNT_BITS-1:0]        r_read_cnt;

   logic w_match;
   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;
   logic w_unused_stream;

   assign w_match = chan_match(i_stream_in[PACKET_BITS-1], i_enable,
                               32'(i_stream_in[c_DST_LSB +: NUM_PORT_BITS]), 32'(CHAN_PORT),
                               32'(i_stream_in[c_SRC_LSB +: c_SRC_BITS]), 32'(i_ctrl));

   assign w_full  = (r_count == c_FULL_COUNT);
   assign w_empty = (r_count == '0);
   // A full FIFO refuses the push even when the same cycle frees an entry.
   assign w_push  = w_match & ~w_full;
   assign w_pop   = ~w_empty & i_ack;

   assign w_unused_stream = ^i_stream_in;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_stream_in[DATA_USER_IN-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_credit           <= '0;
         r_freespace_update <= 1'b0;
         r_overflow         <= 1'b0;
      end else begin
         if (w_pop) begin
            r_credit <= (r_credit == c_CREDIT_LAST) ? '0 : r_credit + 1'b1;
         end
         r_freespace_update <= w_pop & (r_credit == c_CREDIT_LAST);
         if (w_match & w_full) begin
            r_overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_full_cnt  <= '0;
         r_empty_cnt <= '0;
         r_read_cnt  <= '0;
      end else if (!i_done_mode) begin
         if (w_full && (r_full_cnt != '1)) begin
            r_full_cnt <= r_full_cnt + 1'b1;
         end
         if (w_empty && (r_empty_cnt != '1)) begin
            r_empty_cnt <= r_empty_cnt + 1'b1;
         end
         if (w_pop && (r_read_cnt != '1)) begin
            r_read_cnt <= r_read_cnt + 1'b1;
         end
      end
   end

   // RAM is never reset, so the head is masked to zero while empty.
   assign o_dout             = w_empty ? '0 : r_mem[r_rd_ptr];
   assign o_vld              = ~w_empty;
   assign o_overflow         = r_overflow;
   assign o_stall            = w_full & w_match;
   assign o_freespace_update = r_freespace_update;
   assign o_full_cnt         = r_full_cnt;
   assign o_empty_cnt        = r_empty_cnt;
   assign o_read_cnt         = r_read_cnt;

endmodule

`default_nettype wire

// File: rtl/input_port_cluster_gen.sv
// ============================================================================
// Module   : input_port_cluster_gen
// Brief    : Parametrised cluster of leaf input channels with a shared stall flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module input_port_cluster_gen
   import noc_leaf_pkg::*;
#(
   parameter int PACKET_BITS           = PACKET_BITS_DEF,
   parameter int PAYLOAD_BITS          = PAYLOAD_BITS_DEF,
   parameter int NUM_LEAF_BITS         = NUM_LEAF_BITS_DEF,
   parameter int NUM_PORT_BITS         = NUM_PORT_BITS_DEF,
   parameter int NUM_IN_PORTS          = NUM_IN_PORTS_DEF,
   parameter int PORT_BASE             = PORT_BASE_DEF,
   parameter int DATA_USER_IN          = DATA_USER_IN_DEF,
   parameter int FIFO_DEPTH_BITS       = FIFO_DEPTH_BITS_DEF,
   parameter int FREESPACE_UPDATE_SIZE = FREESPACE_UPDATE_SIZE_DEF,
   parameter int CNT_BITS              = CNT_BITS_DEF
) (
   input  logic                                                clk,
   input  logic                                                reset,
   input  logic [PACKET_BITS-1:0]                              stream_in,
   input  logic [(NUM_LEAF_BITS+NUM_PORT_BITS)*NUM_IN_PORTS-1:0] in_control_reg,
   input  logic [NUM_IN_PORTS-1:0]                             port_enable,
   output logic [NUM_IN_PORTS-1:0]                             freespace_update,
   output logic [DATA_USER_IN*NUM_IN_PORTS-1:0]                dout2user,
   output logic [NUM_IN_PORTS-1:0]                             vld2user,
   input  logic [NUM_IN_PORTS-1:0]                             ack_user2b_in,
   output logic [NUM_IN_PORTS-1:0]                             overflow,
   input  logic                                                is_done_mode,
   output logic [CNT_BITS*NUM_IN_PORTS-1:0]                    full_cnt,
   output logic [CNT_BITS*NUM_IN_PORTS-1:0]                    empty_cnt,
   output logic [CNT_BITS*NUM_IN_PORTS-1:0]                    read_cnt,
   output logic                                                stall_condition
);

   localparam int c_SRC_BITS = NUM_LEAF_BITS + NUM_PORT_BITS;

   logic [NUM_IN_PORTS-1:0] w_stall;

   generate
      for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_chan
         input_port_chan #(
            .PACKET_BITS           (PACKET_BITS),
            .NUM_LEAF_BITS         (NUM_LEAF_BITS),
            .NUM_PORT_BITS         (NUM_PORT_BITS),
            .CHAN_PORT             (PORT_BASE + i),
            .DATA_USER_IN          (DATA_USER_IN),
            .FIFO_DEPTH_BITS       (FIFO_DEPTH_BITS),
            .FREESPACE_UPDATE_SIZE (FREESPACE_UPDATE_SIZE),
            .CNT_BITS              (CNT_BITS)
         ) u_chan (
            .clk                (clk),
            .reset              (reset),
            .i_stream_in        (stream_in),
            .i_ctrl             (in_control_reg[i*c_SRC_BITS +: c_SRC_BITS]),
            .i_enable           (port_enable[i]),
            .i_ack              (ack_user2b_in[i]),
            .i_done_mode        (is_done_mode),
            .o_freespace_update (freespace_update[i]),
            .o_dout             (dout2user[i*DATA_USER_IN +: DATA_USER_IN]),
            .o_vld              (vld2user[i]),
            .o_overflow         (overflow[i]),
            .o_stall            (w_stall[i]),
            .o_full_cnt         (full_cnt[i*CNT_BITS +: CNT_BITS]),
            .o_empty_cnt        (empty_cnt[i*CNT_BITS +: CNT_BITS]),
            .o_read_cnt         (read_cnt[i*CNT_BITS +: CNT_BITS])
         );
      end
   endgenerate

   assign stall_condition = |w_stall;

endmodule

`default_nettype wire

// File: tb/tb_input_port_cluster_gen.sv
// ============================================================================
// Module   : tb_input_port_cluster_gen
// Brief    : Directed self-checking bench for input_port_cluster_gen (default parameters).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_input_port_cluster_gen;

   logic         clk = 1'b0;
   logic         reset;
   logic [96:0]  stream_in;
   logic [69:0]  in_control_reg;
   logic [6:0]   port_enable;
   logic [6:0]   freespace_update;
   logic [223:0] dout2user;
   logic [6:0]   vld2user;
   logic [6:0]   ack_user2b_in;
   logic [6:0]   overflow;
   logic         is_done_mode;
   logic [223:0] full_cnt;
   logic [223:0] empty_cnt;
   logic [223:0] read_cnt;
   logic         stall_condition;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   input_port_cluster_gen dut (
      .clk              (clk),
      .reset            (reset),
      .stream_in        (stream_in),
      .in_control_reg   (in_control_reg),
      .port_enable      (port_enable),
      .freespace_update (freespace_update),
      .dout2user        (dout2user),
      .vld2user         (vld2user),
      .ack_user2b_in    (ack_user2b_in),
      .overflow         (overflow),
      .is_done_mode     (is_done_mode),
      .full_cnt         (full_cnt),
      .empty_cnt        (empty_cnt),
      .read_cnt         (read_cnt),
      .stall_condition  (stall_condition)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [96:0] mk_pkt(input logic [3:0] dp, input logic [5:0] sl,
                                          input logic [3:0] sp, input logic [63:0] pl);
      return {1'b1, 6'd0, dp, sl, sp, 12'd0, pl};
   endfunction

   task automatic do_reset();
      reset         = 1'b0;
      stream_in     = '0;
      ack_user2b_in = '0;
      repeat (3) tick();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      int bad_vld;
      tick();
      checks++;
      if (vld2user !== 7'd0 || overflow !== 7'd0 || freespace_update !== 7'd0 || stall_condition !== 1'b0) begin
         failures++;
         $display("FAIL reset_flags vld=%h ovf=%h fsu=%h stall=%b required all 0", vld2user, overflow, freespace_update, stall_condition);
      end
      checks++;
      if (dout2user !== '0 || full_cnt !== '0 || empty_cnt !== '0 || read_cnt !== '0) begin
         failures++;
         $display("FAIL reset_data dout/cnt not zero dout=%h read=%h required 0", dout2user, read_cnt);
      end
      repeat (2) tick();
      reset   = 1'b1;
      bad_vld = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (vld2user !== 7'd0) bad_vld++;
      end
      checks++;
      if (bad_vld != 0) begin
         failures++;
         $display("FAIL idle_vld cycles with vld=%0d required 0", bad_vld);
      end
      checks++;
      if (empty_cnt[31:0] !== 32'd10) begin
         failures++;
         $display("FAIL idle_empty_cnt got %0d required 10", empty_cnt[31:0]);
      end
   endtask

   task automatic test_single_push();
      stream_in = mk_pkt(4'd2, 6'd5, 4'd3, 64'hDEADBEEF_12345678);
      tick();
      stream_in = '0;
      #1;
      checks++;
      if (vld2user !== 7'b0000001) begin
         failures++;
         $display("FAIL single_vld got %b required 0000001", vld2user);
      end
      checks++;
      if (dout2user[31:0] !== 32'h12345678 || dout2user[223:32] !== '0) begin
         failures++;
         $display("FAIL single_dout got %h required 12345678 and others 0", dout2user[63:0]);
      end
      ack_user2b_in = 7'b0000001;
      tick();
      ack_user2b_in = '0;
      checks++;
      if (vld2user !== 7'd0 || read_cnt[31:0] !== 32'd1) begin
         failures++;
         $display("FAIL single_pop vld=%b read=%0d required 0 and 1", vld2user, read_cnt[31:0]);
      end
   endtask

   task automatic test_filter();
      stream_in = mk_pkt(4'd2, 6'd5, 4'd4, 64'h1);
      tick();
      stream_in = '0;
      checks++;
      if (vld2user !== 7'd0) begin
         failures++;
         $display("FAIL filter_src got vld=%b required 0", vld2user);
      end
      port_enable = 7'b1111110;
      stream_in   = mk_pkt(4'd2, 6'd5, 4'd3, 64'h2);
      tick();
      stream_in   = '0;
      port_enable = 7'b1111111;
      checks++;
      if (vld2user !== 7'd0) begin
         failures++;
         $display("FAIL filter_enable got vld=%b required 0", vld2user);
      end
      stream_in = mk_pkt(4'd3, 6'd5, 4'd3, 64'h3);
      tick();
      stream_in = '0;
      checks++;
      if (vld2user !== 7'd0) begin
         failures++;
         $display("FAIL filter_dst got vld=%b required 0", vld2user);
      end
   endtask

   task automatic test_overflow();
      int bad_order;
      for (int i = 0; i < 128; i++) begin
         stream_in = mk_pkt(4'd3, 6'd7, 4'd1, 64'(i));
         tick();
      end
      stream_in = '0;
      #1;
      checks++;
      if (vld2user !== 7'b0000010 || dout2user[63:32] !== 32'd0 || overflow !== 7'd0) begin
         failures++;
         $display("FAIL fill_state vld=%b head=%0d ovf=%b required 0000010 0 0", vld2user, dout2user[63:32], overflow);
      end
      stream_in     = mk_pkt(4'd3, 6'd7, 4'd1, 64'd128);
      ack_user2b_in = 7'b0000010;
      #1;
      checks++;
      if (stall_condition !== 1'b1) begin
         failures++;
         $display("FAIL stall_full got %b required 1", stall_condition);
      end
      tick();
      stream_in = '0;
      #1;
      checks++;
      if (overflow !== 7'b0000010 || full_cnt[63:32] !== 32'd1 || stall_condition !== 1'b0) begin
         failures++;
         $display("FAIL overflow_flag ovf=%b full_cnt=%0d stall=%b required 0000010 1 0", overflow, full_cnt[63:32], stall_condition);
      end
      bad_order = 0;
      for (int i = 1; i < 128; i++) begin
         if (dout2user[63:32] !== 32'(i)) bad_order++;
         tick();
      end
      ack_user2b_in = '0;
      checks++;
      if (bad_order != 0) begin
         failures++;
         $display("FAIL drain_order wrong heads=%0d required 0", bad_order);
      end
      checks++;
      if (vld2user[1] !== 1'b0 || read_cnt[63:32] !== 32'd128) begin
         failures++;
         $display("FAIL drain_end vld=%b read=%0d required 0 128", vld2user[1], read_cnt[63:32]);
      end
   endtask

   task automatic test_credit();
      int pulses;
      int pulse_at;
      do_reset();
      for (int i = 0; i < 64; i++) begin
         stream_in = mk_pkt(4'd2, 6'd5, 4'd3, 64'(i + 100));
         tick();
      end
      stream_in     = '0;
      ack_user2b_in = 7'b0000001;
      pulses        = 0;
      pulse_at      = -1;
      for (int k = 1; k <= 64; k++) begin
         tick();
         if (freespace_update !== 7'd0) begin
            pulses++;
            pulse_at = k;
         end
      end
      ack_user2b_in = '0;
      tick();
      if (freespace_update !== 7'd0) pulses++;
      checks++;
      if (pulses != 1 || pulse_at != 64) begin
         failures++;
         $display("FAIL credit_pulse pulses=%0d at=%0d required 1 at 64", pulses, pulse_at);
      end
      checks++;
      if (read_cnt[31:0] !== 32'd64 || vld2user !== 7'd0 || overflow !== 7'd0) begin
         failures++;
         $display("FAIL credit_read read=%0d vld=%b ovf=%b required 64 0 0", read_cnt[31:0], vld2user, overflow);
      end
   endtask

   task automatic test_back_to_back();
      stream_in = mk_pkt(4'd2, 6'd5, 4'd3, 64'hAAAA_0001);
      tick();
      stream_in     = mk_pkt(4'd2, 6'd5, 4'd3, 64'hBBBB_0002);
      ack_user2b_in = 7'b0000001;
      tick();
      stream_in = '0;
      #1;
      checks++;
      if (vld2user[0] !== 1'b1 || dout2user[31:0] !== 32'hBBBB_0002) begin
         failures++;
         $display("FAIL b2b_head vld=%b dout=%h required 1 bbbb0002", vld2user[0], dout2user[31:0]);
      end
      tick();
      ack_user2b_in = '0;
      checks++;
      if (vld2user[0] !== 1'b0 || read_cnt[31:0] !== 32'd66) begin
         failures++;
         $display("FAIL b2b_drain vld=%b read=%0d required 0 66", vld2user[0], read_cnt[31:0]);
      end
   endtask

   task automatic test_done_mode();
      is_done_mode = 1'b1;
      do_reset();
      repeat (5) tick();
      checks++;
      if (empty_cnt[31:0] !== 32'd0 || read_cnt[31:0] !== 32'd0) begin
         failures++;
         $display("FAIL done_idle empty=%0d read=%0d required 0 0", empty_cnt[31:0], read_cnt[31:0]);
      end
      is_done_mode = 1'b0;
      repeat (3) tick();
      checks++;
      if (empty_cnt[31:0] !== 32'd3) begin
         failures++;
         $display("FAIL done_release empty=%0d required 3", empty_cnt[31:0]);
      end
      stream_in = mk_pkt(4'd2, 6'd5, 4'd3, 64'h11);
      tick();
      stream_in = mk_pkt(4'd2, 6'd5, 4'd3, 64'h22);
      tick();
      stream_in     = '0;
      ack_user2b_in = 7'b0000001;
      tick();
      is_done_mode = 1'b1;
      tick();
      ack_user2b_in = '0;
      repeat (3) tick();
      checks++;
      if (read_cnt[31:0] !== 32'd1 || empty_cnt[31:0] !== 32'd4) begin
         failures++;
         $display("FAIL done_freeze read=%0d empty=%0d required 1 4", read_cnt[31:0], empty_cnt[31:0]);
      end
      is_done_mode = 1'b0;
      stream_in    = mk_pkt(4'd2, 6'd5, 4'd3, 64'h33);
      repeat (3) tick();
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (vld2user !== 7'd0 || read_cnt !== '0 || empty_cnt !== '0 || full_cnt !== '0 || dout2user !== '0) begin
         failures++;
         $display("FAIL async_reset vld=%b read=%0d empty=%0d required all 0", vld2user, read_cnt[31:0], empty_cnt[31:0]);
      end
      stream_in = '0;
      tick();
      reset = 1'b1;
   endtask

   initial begin
      reset          = 1'b0;
      stream_in      = '0;
      ack_user2b_in  = '0;
      is_done_mode   = 1'b0;
      port_enable    = 7'b1111111;
      in_control_reg = {7{10'h3FF}};
      in_control_reg[9:0]   = {6'd5, 4'd3};
      in_control_reg[19:10] = {6'd7, 4'd1};

      test_reset();
      test_single_push();
      test_filter();
      test_overflow();
      test_credit();
      test_back_to_back();
      test_done_mode();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
